// File: rtl/mult_seq_ctrl.sv
// Multi-cycle signed shift-add multiply sequencer for the EX-stage mult op; stalls the pipeline
// and writes the 2W-bit product into HI/LO. Optional MULT_EARLY_TERM_EN stops RUN once mplier empties.
module mult_seq_ctrl #(
  parameter int unsigned W         = 32,
  parameter logic [3:0]  MULT_CODE = 4'b0011
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [3:0]   alu_ctrl_i,
  input  logic         is_jr_i,
  input  logic         flush_i,
  input  logic [W-1:0] src1_i,
  input  logic [W-1:0] src2_i,
  output logic         stall_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] result_hi_o,
  output logic [W-1:0] result_lo_o
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  logic            start;
  logic [W-1:0]    abs1, abs2;
  logic [2*W-1:0]  prod;

  assign start = valid_i & (alu_ctrl_i == MULT_CODE) & ~is_jr_i & ~flush_i;

  // Magnitudes as unsigned; the most negative value maps onto itself, which is correct unsigned.
  assign abs1 = src1_i[W-1] ? -src1_i : src1_i;
  assign abs2 = src2_i[W-1] ? -src2_i : src2_i;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    prod     = '0;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            mcand_d  = {{W{1'b0}}, abs1};
            mplier_d = abs2;
            sign_d   = src1_i[W-1] ^ src2_i[W-1];
            acc_d    = '0;
            cnt_d    = CntW'(W - 1);
            state_d  = StRun;
          end
        end
        StRun: begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
`ifdef MULT_EARLY_TERM_EN
          if ((cnt_q == '0) || (mplier_d == '0)) begin
`else
          if (cnt_q == '0) begin
`endif
            state_d = StFix;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StFix: begin
          prod    = sign_q ? -acc_q : acc_q;
          hi_d    = prod[2*W-1:W];
          lo_d    = prod[W-1:0];
          state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Reset gating keeps stall low while reset is held even if a mult is presented.
  assign stall_o = rst_i & ~flush_i &
                   (((state_q == StIdle) & start) | (state_q == StRun) | (state_q == StFix));
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone) & ~flush_i;
  assign result_hi_o = hi_q;
  assign result_lo_o = lo_q;

endmodule
